// File: rtl/hamming_secded_decoder_if.sv
// Codeword-in / result-out handshake bundle for the (16,11) SECDED decoder.
// The slave modport is the decoder side; master is the upstream/downstream side.
interface hamming_secded_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_codeword;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic        out_corrected;
  logic        out_uncorrectable;
  logic [3:0]  out_err_pos;

  modport slave (
    input  in_valid, in_codeword, out_ready,
    output in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_err_pos
  );

  modport master (
    output in_valid, in_codeword, out_ready,
    input  in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_err_pos
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Extended Hamming (16,11) SECDED decoder: stage 1 computes syndrome and parity,
// stage 2 corrects/classifies; saturating event counters count delivered words.
module hamming_secded_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  hamming_secded_decoder_if.slave bus,
  input  logic                    cnt_clear,
  output logic [CNT_W-1:0]        cnt_corrected,
  output logic [CNT_W-1:0]        cnt_uncorrectable
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [10:0] data;
    logic        corrected;
    logic        uncorrectable;
    logic [3:0]  err_pos;
  } result_t;

  function automatic logic [3:0] calc_syndrome(input logic [15:0] cw);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i < 16; i++) begin
      if (cw[i]) s = s ^ 4'(i);
    end
    return s;
  endfunction

  // Data bits sit at every non-power-of-two index, LSB first.
  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

  logic        s1_valid;
  logic [15:0] s1_cw;
  logic [3:0]  s1_syn;
  logic        s1_par;
  logic        s1_advance;
  logic        accept;

  logic        s2_valid;
  result_t     s1_res;
  result_t     s2_res;
  logic        out_xfer;

  // Stage 1 may move whenever stage 2 is empty or draining; never looks at in_valid.
  assign s1_advance   = !s2_valid || bus.out_ready;
  assign bus.in_ready = rst || !s1_valid || s1_advance;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
    end
  end

  // NOTE: payload registers are qualified by s1_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_cw  <= bus.in_codeword;
      s1_syn <= calc_syndrome(bus.in_codeword);
      s1_par <= ^bus.in_codeword;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    logic [15:0] fixed_cw;
    fixed_cw = s1_cw;
    s1_res   = '0;
    if (s1_par) begin
      // Odd overall parity: exactly one flip, syndrome 0 points at bit 0.
      fixed_cw[s1_syn] = ~s1_cw[s1_syn];
      s1_res.corrected = 1'b1;
      s1_res.err_pos   = s1_syn;
    end else if (s1_syn != 4'd0) begin
      s1_res.uncorrectable = 1'b1;
    end
    s1_res.data = extract_data(fixed_cw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_res <= s1_res;
    end
  end

  assign bus.out_valid         = s2_valid;
  assign bus.out_data          = s2_res.data;
  assign bus.out_corrected     = s2_res.corrected;
  assign bus.out_uncorrectable = s2_res.uncorrectable;
  assign bus.out_err_pos       = s2_res.err_pos;

  // Statistics count delivered words; a clear wins over a same-cycle increment.
  assign out_xfer = s2_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (out_xfer) begin
      if (s2_res.corrected && cnt_corrected != CNT_MAX)
        cnt_corrected <= cnt_corrected + 1'b1;
      if (s2_res.uncorrectable && cnt_uncorrectable != CNT_MAX)
        cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: nearest-codeword reference model plus
// directed vectors with literal expectations.
module tb_hamming_secded_decoder;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cnt_clear;
  logic [CNT_W-1:0] cnt_corrected;
  logic [CNT_W-1:0] cnt_uncorrectable;

  hamming_secded_decoder_if bus ();

  hamming_secded_decoder #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .cnt_clear        (cnt_clear),
    .cnt_corrected    (cnt_corrected),
    .cnt_uncorrectable(cnt_uncorrectable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] data;
    logic        corr;
    logic        unc;
    logic [3:0]  pos;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   acc_count = 0;
  exp_t q[$];
  int   m_cc = 0;
  int   m_cu = 0;
  bit   held = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  // A word is a codeword when every Hamming group and the whole word have even parity.
  function automatic bit is_codeword(input logic [15:0] c);
    bit p;
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int i = 1; i < 16; i++) if (((i >> k) & 1) == 1) p = p ^ c[i];
      if (p) return 1'b0;
    end
    return (^c) == 1'b0;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    for (int j = 0; j < 11; j++) d[j] = c[dpos[j]];
    return d;
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    bit p;
    c = '0;
    for (int j = 0; j < 11; j++) c[dpos[j]] = d[j];
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int i = 1; i < 16; i++) if (((i >> k) & 1) == 1) p = p ^ c[i];
      c[1 << k] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Decode by searching for a codeword within distance one of the received word.
  function automatic exp_t model(input logic [15:0] c);
    exp_t e;
    logic [15:0] t;
    e.data = extract(c); e.corr = 1'b0; e.unc = 1'b0; e.pos = 4'd0;
    if (is_codeword(c)) return e;
    for (int j = 0; j < 16; j++) begin
      t = c ^ (16'd1 << j);
      if (is_codeword(t)) begin
        e.data = extract(t); e.corr = 1'b1; e.pos = 4'(j);
        return e;
      end
    end
    e.unc = 1'b1;
    return e;
  endfunction

  // Compare process: runs on every falling edge.
  always @(negedge clk) begin
    exp_t h;
    if (rst) begin
      check("in_ready_in_reset", bus.in_ready, 1'b1);
      q.delete();
      m_cc = 0; m_cu = 0; held = 0;
    end else begin
      check("cnt_corrected", cnt_corrected, m_cc);
      check("cnt_uncorrectable", cnt_uncorrectable, m_cu);
      if (held) check("out_valid_held", bus.out_valid, 1'b1);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          h = q[0];
          check("out_data", bus.out_data, h.data);
          check("out_corrected", bus.out_corrected, h.corr);
          check("out_uncorrectable", bus.out_uncorrectable, h.unc);
          check("out_err_pos", bus.out_err_pos, h.pos);
          if (bus.out_ready) begin
            void'(q.pop_front());
            if (cnt_clear) begin m_cc = 0; m_cu = 0; end
            else begin
              if (h.corr && m_cc < CMAX) m_cc++;
              if (h.unc && m_cu < CMAX) m_cu++;
            end
          end
        end
      end
      if (!(bus.out_valid && bus.out_ready) && cnt_clear) begin m_cc = 0; m_cu = 0; end
      held = bus.out_valid && !bus.out_ready;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_codeword));
        acc_count++;
      end
    end
  end

  task automatic send(input logic [15:0] cw);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_codeword = cw;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 30);
    if (!bus.out_valid) check("wait_out_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((q.size() != 0 || bus.out_valid) && n < 40);
    check("drain_done", q.size(), 0);
  endtask

  task automatic clear_counters();
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
  endtask

  logic [15:0] bp_words[4];
  exp_t        me;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cnt_clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_codeword = '0; bus.out_ready = 1'b1;

    // Pin the reference model against hand-decoded words.
    check("enc_7ff", encode(11'h7FF), 16'hFFFF);
    check("enc_000", encode(11'h000), 16'h0000);
    me = model(16'hFFFF);
    check("model_ffff", {me.data, me.corr, me.unc, me.pos}, {11'h7FF, 1'b0, 1'b0, 4'd0});
    me = model(16'h0020);
    check("model_0020", {me.data, me.corr, me.unc, me.pos}, {11'h000, 1'b1, 1'b0, 4'd5});
    me = model(16'hFFFE);
    check("model_fffe", {me.data, me.corr, me.unc, me.pos}, {11'h7FF, 1'b1, 1'b0, 4'd0});
    me = model(16'h0028);
    check("model_0028", {me.data, me.corr, me.unc, me.pos}, {11'h003, 1'b0, 1'b1, 4'd0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_fields", {bus.out_data, bus.out_corrected, bus.out_uncorrectable, bus.out_err_pos}, '0);
    check("rst_counters", {cnt_corrected, cnt_uncorrectable}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean word and two-cycle latency.
    bus.in_valid = 1'b1; bus.in_codeword = 16'hFFFF;
    @(negedge clk);
    check("lat_accept_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", bus.out_valid, 1'b0);
    @(negedge clk);
    check("lat_valid", bus.out_valid, 1'b1);
    check("clean_data", bus.out_data, 11'h7FF);
    check("clean_flags", {bus.out_corrected, bus.out_uncorrectable, bus.out_err_pos}, 6'd0);
    @(posedge clk); #1;

    // Single error on a data bit.
    send(16'h0020);
    wait_out();
    check("se_data", bus.out_data, 11'h000);
    check("se_corr", bus.out_corrected, 1'b1);
    check("se_pos", bus.out_err_pos, 4'd5);
    @(negedge clk);
    check("se_cnt", cnt_corrected, 1);

    // Single error on overall parity bit.
    send(16'hFFFE);
    wait_out();
    check("p0_data", bus.out_data, 11'h7FF);
    check("p0_corr", bus.out_corrected, 1'b1);
    check("p0_pos", bus.out_err_pos, 4'd0);
    @(negedge clk);
    check("p0_cnt", cnt_corrected, 2);

    // Double error.
    send(16'h0028);
    wait_out();
    check("de_unc", bus.out_uncorrectable, 1'b1);
    check("de_corr", bus.out_corrected, 1'b0);
    check("de_pos", bus.out_err_pos, 4'd0);
    check("de_data", bus.out_data, 11'h003);
    @(negedge clk);
    check("de_cnt", cnt_uncorrectable, 1);
    @(posedge clk); #1;

    // Backpressure: four words, sink stalled for five cycles.
    clear_counters();
    bp_words[0] = encode(11'h123) ^ 16'h0040;
    bp_words[1] = encode(11'h456);
    bp_words[2] = encode(11'h7AB) ^ 16'h0804;
    bp_words[3] = encode(11'h055) ^ 16'h8000;
    bus.out_ready = 1'b0;
    begin
      int base;
      base = acc_count;
      fork
        for (int i = 0; i < 4; i++) send(bp_words[i]);
        begin
          repeat (5) @(negedge clk);
          check("bp_accepts", acc_count - base, 2);
          check("bp_in_ready", bus.in_ready, 1'b0);
          check("bp_out_valid", bus.out_valid, 1'b1);
          @(posedge clk); #1;
          bus.out_ready = 1'b1;
        end
      join
    end
    drain();
    check("bp_cnt_corr", cnt_corrected, 2);
    check("bp_cnt_unc", cnt_uncorrectable, 1);

    // Saturation with CNT_W=2, then clear colliding with a delivery.
    clear_counters();
    for (int i = 0; i < 5; i++) send(encode(11'(i * 37 + 1)) ^ (16'd1 << (i + 1)));
    drain();
    check("sat_cnt", cnt_corrected, 3);
    bus.out_ready = 1'b0;
    send(encode(11'h3C3) ^ 16'h2000);
    wait_out();
    @(posedge clk); #1;
    cnt_clear = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    @(negedge clk);
    check("clr_cnt", cnt_corrected, 0);
    check("clr_out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;

    // Reset with words in flight.
    send(encode(11'h0F0) ^ 16'h0200);
    drain();
    check("pre_rst_cnt", cnt_corrected, 1);
    bus.in_valid = 1'b1; bus.in_codeword = encode(11'h111) ^ 16'h0008;
    @(posedge clk); #1;
    bus.in_codeword = encode(11'h222) ^ 16'h1000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", bus.out_valid, 1'b0);
    check("rst_mid_cnt", {cnt_corrected, cnt_uncorrectable}, '0);
    @(negedge clk);
    check("rst_mid_still_empty", bus.out_valid, 1'b0);
    @(posedge clk); #1;

    send(encode(11'h2AA));
    wait_out();
    check("post_rst_data", bus.out_data, 11'h2AA);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
